stage2: RTL and testbench



---
 rtl/aes_pkg.sv | 31 +++
 rtl/round_tail.sv | 17 +
 rtl/stage2.sv | 61 ++++++
 tb/tb_stage2.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES round constants, block record and GF(2^8) round helpers
package aes_pkg;
  localparam int LAST_ROUND_DEFAULT = 10;
  typedef struct packed {
    logic [127:0] state;
    logic [3:0]   num;
    logic         last;
  } blk_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
    return o;
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction
endpackage

// File: rtl/round_tail.sv
// round_tail: ShiftRows -> MixColumns (skipped on last round) -> AddRoundKey; in state/key/num, out state_out/last
module round_tail
  import aes_pkg::*;
#(
  parameter int LAST_ROUND = LAST_ROUND_DEFAULT
) (
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [3:0]   num,
  output logic [127:0] state_out,
  output logic         last
);
  logic [127:0] sr;
  assign sr        = shift_rows(state);
  assign last      = num == 4'(LAST_ROUND);
  assign state_out = (last ? sr : mix_columns(sr)) ^ key;
endmodule

// File: rtl/stage2.sv
// stage2: AES round tail with valid/ready output register and one-entry skid; ports clk/rst/en, in_valid/in_ready/state/key/num, out_valid/out_ready/state_out/num_out/last_out, err
module stage2
  import aes_pkg::*;
#(
  parameter int LAST_ROUND = LAST_ROUND_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [3:0]   num,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [3:0]   num_out,
  output logic         last_out,
  output logic         err
);
  blk_t out_q, skid_q, in_blk;
  logic out_v, skid_v, accept, bad;
  logic [127:0] rt_state;
  logic rt_last;
  round_tail #(.LAST_ROUND(LAST_ROUND)) u_tail (
    .state(state), .key(key), .num(num), .state_out(rt_state), .last(rt_last)
  );
  assign in_blk    = '{state: rt_state, num: num, last: rt_last};
  assign in_ready  = !skid_v;
  assign accept    = in_valid && in_ready && en;
  assign bad       = num == 4'd0 || num > 4'(LAST_ROUND);
  assign out_valid = out_v;
  assign state_out = out_q.state;
  assign num_out   = out_q.num;
  assign last_out  = out_q.last;
  // in_ready is low whenever SKID is full, so an accept never coincides with a SKID->OUT move
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_q  <= '0;
      out_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
      err    <= 1'b0;
    end else if (en) begin
      if (!out_v || out_ready) begin
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else begin
          out_v <= accept;
          if (accept) out_q <= in_blk;
        end
      end else if (accept) begin
        skid_q <= in_blk;
        skid_v <= 1'b1;
      end
      if (accept && bad) err <= 1'b1;
    end
endmodule

// File: tb/tb_stage2.sv
// tb_stage2: table-driven vectors plus scoreboard for stage2
module tb_stage2;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] state = '0, key = '0;
  logic [3:0] num = '0;
  logic in_ready, out_valid, last_out, err;
  logic [127:0] state_out;
  logic [3:0] num_out;
  stage2 dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .state(state), .key(key), .num(num), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .num_out(num_out), .last_out(last_out), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [127:0] st, k, ex;
    logic [3:0] n;
    logic last;
  } vec_t;
  typedef struct packed {
    logic [127:0] st;
    logic [3:0] n;
    logic last;
  } exp_t;
  vec_t tbl[11];
  exp_t sb[$];
  exp_t cur;
  int n_cmp = 0, n_bad = 0, n_pop = 0;
  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_in(input int i);
    state = tbl[i].st;
    key   = tbl[i].k;
    num   = tbl[i].n;
    cur   = '{st: tbl[i].ex, n: tbl[i].n, last: tbl[i].last};
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && en) begin
      chk("in_ready_vs_occupancy", in_ready, sb.size() < 2);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_output", out_valid, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_out", {state_out, num_out, last_out}, e);
          n_pop++;
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c, sent, p0;
    tbl[0]  = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0};
    tbl[1]  = '{128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h3925841d02dc09fbdc118597196a0b32, 4'd10, 1'b1};
    tbl[2]  = '{128'h0, 128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210, 4'd1, 1'b0};
    tbl[3]  = '{{16{8'h01}}, 128'h0, {16{8'h01}}, 4'd5, 1'b0};
    tbl[4]  = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h00050a0f04090e03080d02070c01060b, 4'd10, 1'b1};
    tbl[5]  = '{{16{8'h01}}, {16{8'hff}}, {16{8'hfe}}, 4'd10, 1'b1};
    tbl[6]  = '{{4{32'hdb135345}}, 128'h0, {4{32'h8e4da1bc}}, 4'd2, 1'b0};
    tbl[7]  = '{{4{32'hd4d4d4d5}}, 128'h0, {4{32'hd5d5d7d6}}, 4'd9, 1'b0};
    tbl[8]  = '{{4{32'hf20a225c}}, 128'h0, {4{32'h9fdc589d}}, 4'd3, 1'b0};
    tbl[9]  = '{128'h0, 128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0};
    tbl[10] = '{{4{32'hdb135345}}, 128'h0, {4{32'h8e4da1bc}}, 4'd11, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state_out", state_out, 0);
    chk("rst_num_out", num_out, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      set_in(i);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_state", i), state_out, tbl[i].ex);
      chk($sformatf("vec%0d_num", i), num_out, tbl[i].n);
      chk($sformatf("vec%0d_last", i), last_out, tbl[i].last);
      tick();
    end
    c = 0;
    sent = 0;
    p0 = n_pop;
    while ((sent < 8 || sb.size() != 0) && c < 60) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid = sent < 8;
      if (sent < 8) set_in(sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_within_budget", c < 60, 1);
    chk("stream_block_count", n_pop - p0, 8);
    set_in(1);
    in_valid = 1'b1;
    tick();
    set_in(2);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("en_low_out_valid", out_valid, 1);
      chk("en_low_state_held", state_out, tbl[1].ex);
      tick();
    end
    en = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("en_resume_state", state_out, tbl[2].ex);
    tick();
    chk("err_before_bad", err, 0);
    set_in(9);
    in_valid = 1'b1;
    tick();
    set_in(10);
    @(negedge clk);
    chk("err_after_num0", err, 1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("err_sticky", err, 1);
    out_ready = 1'b0;
    set_in(0);
    in_valid = 1'b1;
    tick();
    set_in(1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_err", err, 0);
    sb.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_in(4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_state", state_out, tbl[4].ex);
    tick();
    @(negedge clk);
    chk("post_rst_alone", out_valid, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
